// File: rtl/studio2_keypad_pkg.sv
// studio2_keypad_pkg: keypad scancode tables, key vector type and scancode decoder
package studio2_keypad_pkg;
  localparam int KEYS = 10;
  localparam int TW = 24;
  typedef logic [KEYS-1:0] key_vec_t;
  typedef logic [7:0] code_tab_t [KEYS];
  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;
  localparam code_tab_t KP1_CODES = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam code_tab_t KP2_CODES = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  function automatic key_hit_t decode_key(input logic [7:0] code, input code_tab_t tab);
    decode_key = '0;
    for (int i = 0; i < KEYS; i++)
      if (tab[i] == code) decode_key = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/studio2_keypad_if.sv
// studio2_keypad_if: cdp1802 OUT/EF side of the keypad
interface studio2_keypad_if;
  logic       io_out;
  logic [2:0] io_n;
  logic [7:0] io_dout;
  logic [3:0] key_sel;
  logic       ef3_n;
  logic       ef4_n;
  modport master (output io_out, io_n, io_dout, input key_sel, ef3_n, ef4_n);
  modport slave (input io_out, io_n, io_dout, output key_sel, ef3_n, ef4_n);
endinterface

// File: rtl/studio2_keypad_bank.sv
// studio2_keypad_bank: one 10-key pad with a shared hold timer that defers releases
module studio2_keypad_bank
  import studio2_keypad_pkg::*;
#(
  parameter logic [TW-1:0] HOLD_CYCLES = 24'd3_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic       lift,
  input  logic [3:0] idx,
  output key_vec_t   keys
);
  key_vec_t pending, keys_d, pending_d;
  logic [TW-1:0] timer, timer_d;
  logic expire;
  // expiry mask first, then the key event so a press wins over its own deferred release
  always_comb begin
    expire = timer == TW'(1);
    keys_d = expire ? keys & ~pending : keys;
    pending_d = expire ? '0 : pending;
    timer_d = timer != '0 ? timer - TW'(1) : timer;
    if (press) begin
      keys_d[idx] = 1'b1;
      pending_d[idx] = 1'b0;
      timer_d = HOLD_CYCLES;
    end else if (lift && keys_d[idx]) begin
      if (timer_d == '0) keys_d[idx] = 1'b0;
      else pending_d[idx] = 1'b1;
    end
  end
  // bank state register
  always_ff @(posedge clk) begin
    if (reset) begin
      keys <= '0;
      pending <= '0;
      timer <= '0;
    end else begin
      keys <= keys_d;
      pending <= pending_d;
      timer <= timer_d;
    end
  end
endmodule

// File: rtl/studio2_keypad.sv
// studio2_keypad: ps2_key events to two Studio II keypads polled through OUT 2 and EF3/EF4
module studio2_keypad
  import studio2_keypad_pkg::*;
#(
  parameter logic [TW-1:0] HOLD_CYCLES = 24'd3_500_000,
  parameter logic [2:0]    SEL_PORT    = 3'd2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       ps2_key,
  studio2_keypad_if.slave   bus,
  output key_vec_t          kp1_keys,
  output key_vec_t          kp2_keys
);
  logic tog_q, evt;
  key_hit_t h1, h2;
  logic [15:0] k1, k2;
  // event on toggle edge, extended codes dropped; key vectors padded so selects 10..15 read 0
  always_comb begin
    evt = (ps2_key[10] != tog_q) && !ps2_key[8];
    h1 = decode_key(ps2_key[7:0], KP1_CODES);
    h2 = decode_key(ps2_key[7:0], KP2_CODES);
    k1 = 16'(kp1_keys);
    k2 = 16'(kp2_keys);
  end
  // toggle copy also reloads during reset so no stale edge fires afterwards
  always_ff @(posedge clk) tog_q <= ps2_key[10];
  studio2_keypad_bank #(.HOLD_CYCLES(HOLD_CYCLES)) u_kp1 (
    .clk(clk), .reset(reset),
    .press(evt && h1.hit && ps2_key[9]), .lift(evt && h1.hit && !ps2_key[9]),
    .idx(h1.idx), .keys(kp1_keys)
  );
  studio2_keypad_bank #(.HOLD_CYCLES(HOLD_CYCLES)) u_kp2 (
    .clk(clk), .reset(reset),
    .press(evt && h2.hit && ps2_key[9]), .lift(evt && h2.hit && !ps2_key[9]),
    .idx(h2.idx), .keys(kp2_keys)
  );
  // key-select latch and registered active-low EF flags
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.key_sel <= '0;
      bus.ef3_n <= 1'b1;
      bus.ef4_n <= 1'b1;
    end else begin
      if (bus.io_out && bus.io_n == SEL_PORT) bus.key_sel <= bus.io_dout[3:0];
      bus.ef3_n <= ~k1[bus.key_sel];
      bus.ef4_n <= ~k2[bus.key_sel];
    end
  end
endmodule
